csi_raw_unpacker: RTL

- Downstream of the CSI-2 packet receiver; consumes its 32-bit little-endian payload words (byte 0 = bits 7:0) and short-packet sync decodes.
- Unpacks RAW10 (DT 0x2B) and RAW8 (DT 0x2A) long-packet payloads into groups of 4 pixels, 10 bits each, with frame/line markers, line counting and residue error flagging for the ISP/framebuffer writer.

---
 rtl/csi_pkg.sv | 25 ++
 rtl/csi_raw_unpacker_if.sv | 43 ++++
 rtl/csi_raw10_gearbox.sv | 61 ++++++
 rtl/csi_raw_unpacker.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 constants, pixel-group geometry and the unpacker state type.
package csi_pkg;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;
  localparam logic [5:0] DT_RAW8        = 6'h2A;
  localparam logic [5:0] DT_RAW10       = 6'h2B;

  localparam int PIXELS_PER_GROUP = 4;
  localparam int PIXEL_WIDTH      = 10;
  localparam int GROUP_WIDTH      = PIXELS_PER_GROUP * PIXEL_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  // Widen one RAW8 sample to the 10-bit pixel format.
  function automatic logic [PIXEL_WIDTH-1:0] raw8_pixel(input logic [7:0] b, input bit left_align);
    return left_align ? {b, 2'b00} : {2'b00, b};
  endfunction

endpackage

// File: rtl/csi_raw_unpacker_if.sv
// Receiver-side payload/sync inputs and unpacked pixel-group outputs of the unpacker.
interface csi_raw_unpacker_if #(
  parameter int LINE_COUNT_WIDTH = 16
);
  import csi_pkg::*;

  // Valid-only strobes, no backpressure: image_data_enable and interrupt are
  // single-cycle strobes from the receiver; pixel_valid, line_done and
  // frame_done are single-cycle strobes that the consumer must take when seen.
  logic [31:0]                 image_data;
  logic                        image_data_enable;
  logic [5:0]                  image_data_type;
  logic                        interrupt;
  logic                        frame_start;
  logic                        frame_end;
  logic                        line_start;
  logic                        line_end;

  logic [GROUP_WIDTH-1:0]      pixel_data;
  logic                        pixel_valid;
  logic                        pixel_line_first;
  logic                        pixel_frame_first;
  logic                        line_done;
  logic                        frame_done;
  logic [LINE_COUNT_WIDTH-1:0] line_count;
  logic                        residue_error;
  state_e                      dbg_state;

  modport master (
    output image_data, image_data_enable, image_data_type, interrupt,
           frame_start, frame_end, line_start, line_end,
    input  pixel_data, pixel_valid, pixel_line_first, pixel_frame_first,
           line_done, frame_done, line_count, residue_error, dbg_state
  );

  modport slave (
    input  image_data, image_data_enable, image_data_type, interrupt,
           frame_start, frame_end, line_start, line_end,
    output pixel_data, pixel_valid, pixel_line_first, pixel_frame_first,
           line_done, frame_done, line_count, residue_error, dbg_state
  );

endinterface

// File: rtl/csi_raw10_gearbox.sv
// RAW10 byte buffer: appends 4-byte words and peels off one 5-byte group as 4 pixels.
module csi_raw10_gearbox
  import csi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   flush_i,
  input  logic [31:0]            word_i,
  output logic                   group_valid_o,
  output logic [GROUP_WIDTH-1:0] group_o,
  output logic [3:0]             count_o
);

  // Byte 0 (oldest) lives in bits 7:0; bytes above count_q are kept zero.
  logic [63:0] buf_q, buf_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  base;
  logic [3:0]  total;
  logic [63:0] held;
  logic [63:0] merged;

  always_comb begin
    base          = flush_i ? 4'd0 : count_q;
    held          = flush_i ? 64'd0 : buf_q;
    merged        = held | ({32'd0, word_i} << {base, 3'b000});
    total         = base + 4'd4;
    group_valid_o = push_i && (total >= 4'd5);
    group_o       = '0;
    for (int i = 0; i < PIXELS_PER_GROUP; i++) begin
      group_o[PIXEL_WIDTH*i +: PIXEL_WIDTH] = {merged[8*i +: 8], merged[32+2*i +: 2]};
    end
    buf_d   = buf_q;
    count_d = count_q;
    if (push_i) begin
      if (total >= 4'd5) begin
        buf_d   = merged >> 40;
        count_d = total - 4'd5;
      end else begin
        buf_d   = merged;
        count_d = total;
      end
    end else if (flush_i) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csi_raw_unpacker.sv
// Frame/line tracker that turns RAW8/RAW10 CSI-2 payload words into registered 4-pixel groups.
module csi_raw_unpacker
  import csi_pkg::*;
#(
  parameter int LINE_COUNT_WIDTH = 16,
  parameter bit RAW8_LEFT_ALIGN  = 1'b1
)(
  input  logic               clock_p,
  input  logic               reset_n,
  csi_raw_unpacker_if.slave  bus
);

  state_e                      state_q, state_d;
  logic [LINE_COUNT_WIDTH-1:0] lc_q, lc_d;
  logic                        res_q, res_d;
  logic                        lfp_q, lfp_d;
  logic                        ffp_q, ffp_d;
  logic                        open_q, open_d;
  logic [5:0]                  pdt_q, pdt_d;
  logic                        pdtv_q, pdtv_d;
  logic [GROUP_WIDTH-1:0]      pix_q, pix_d;
  logic                        pv_q, pv_d;
  logic                        plf_q, plf_d;
  logic                        pff_q, pff_d;
  logic                        ld_q, ld_d;
  logic                        fd_q, fd_d;

  logic                        in_frame, acc, is_raw10, is_raw8;
  logic                        close, count_inc, emit;
  logic                        gb_push, gb_flush, gb_valid;
  logic [GROUP_WIDTH-1:0]      gb_group, raw8_group;
  logic [3:0]                  gb_count;

  csi_raw10_gearbox u_gearbox (
    .clk           (clock_p),
    .rst_n         (reset_n),
    .push_i        (gb_push),
    .flush_i       (gb_flush),
    .word_i        (bus.image_data),
    .group_valid_o (gb_valid),
    .group_o       (gb_group),
    .count_o       (gb_count)
  );

  always_comb begin
    raw8_group = '0;
    for (int i = 0; i < PIXELS_PER_GROUP; i++) begin
      raw8_group[PIXEL_WIDTH*i +: PIXEL_WIDTH] = raw8_pixel(bus.image_data[8*i +: 8], RAW8_LEFT_ALIGN);
    end
  end

  always_comb begin
    state_d   = state_q;
    lc_d      = lc_q;
    res_d     = res_q;
    lfp_d     = lfp_q;
    ffp_d     = ffp_q;
    open_d    = open_q;
    pdt_d     = pdt_q;
    pdtv_d    = pdtv_q;
    pix_d     = pix_q;
    pv_d      = 1'b0;
    plf_d     = 1'b0;
    pff_d     = 1'b0;
    ld_d      = 1'b0;
    fd_d      = 1'b0;
    close     = 1'b0;
    count_inc = 1'b0;
    gb_flush  = 1'b0;
    in_frame  = (state_q == FRAME);
    acc       = in_frame && bus.image_data_enable;
    is_raw10  = (bus.image_data_type == DT_RAW10);
    is_raw8   = (bus.image_data_type == DT_RAW8);
    gb_push   = acc && is_raw10;

    // A data strobe always wins; sync levels only mean something on a short-event cycle.
    if (bus.image_data_enable) begin
      if (in_frame) begin
        if (pdtv_q && (bus.image_data_type != pdt_q)) close = 1'b1;
        pdt_d  = bus.image_data_type;
        pdtv_d = 1'b1;
      end
    end else if (bus.interrupt) begin
      if (in_frame && bus.frame_end) begin
        close     = 1'b1;
        count_inc = open_q;
        fd_d      = 1'b1;
        state_d   = IDLE;
      end else if (bus.frame_start) begin
        state_d  = FRAME;
        lc_d     = '0;
        res_d    = 1'b0;
        ffp_d    = 1'b1;
        lfp_d    = 1'b1;
        open_d   = 1'b0;
        pdtv_d   = 1'b0;
        gb_flush = 1'b1;
      end else if (in_frame && bus.line_end) begin
        close     = 1'b1;
        count_inc = 1'b1;
      end else if (in_frame && bus.line_start) begin
        close = 1'b1;
      end
    end

    if (close) begin
      gb_flush = 1'b1;
      lfp_d    = 1'b1;
      open_d   = 1'b0;
      if (gb_count != 4'd0) res_d = 1'b1;
    end
    if (acc) open_d = 1'b1;

    if (count_inc) begin
      ld_d = 1'b1;
      if (lc_q != '1) lc_d = lc_q + LINE_COUNT_WIDTH'(1);
    end

    // A type-change close in this same cycle re-arms line_first before the group goes out.
    emit = acc && ((is_raw10 && gb_valid) || is_raw8);
    if (emit) begin
      pv_d  = 1'b1;
      plf_d = lfp_d;
      pff_d = ffp_q;
      lfp_d = 1'b0;
      ffp_d = 1'b0;
      pix_d = is_raw10 ? gb_group : raw8_group;
    end
  end

  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lc_q    <= '0;
      res_q   <= 1'b0;
      lfp_q   <= 1'b0;
      ffp_q   <= 1'b0;
      open_q  <= 1'b0;
      pdt_q   <= '0;
      pdtv_q  <= 1'b0;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      plf_q   <= 1'b0;
      pff_q   <= 1'b0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      res_q   <= res_d;
      lfp_q   <= lfp_d;
      ffp_q   <= ffp_d;
      open_q  <= open_d;
      pdt_q   <= pdt_d;
      pdtv_q  <= pdtv_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      plf_q   <= plf_d;
      pff_q   <= pff_d;
      ld_q    <= ld_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.pixel_data        = pix_q;
  assign bus.pixel_valid       = pv_q;
  assign bus.pixel_line_first  = plf_q;
  assign bus.pixel_frame_first = pff_q;
  assign bus.line_done         = ld_q;
  assign bus.frame_done        = fd_q;
  assign bus.line_count        = lc_q;
  assign bus.residue_error     = res_q;
  assign bus.dbg_state         = state_q;

endmodule
